sparse_mvm_core: RTL and testbench

Parametrised successor to the fixed 4x4 sparse matrix-vector multiply accelerator. Computes y = A·x, where:
- x is a dense N-entry signed vector, loaded first.
- A is streamed as sparse COO triplets (row, col, value).
- Each nonzero costs one cycle; zero entries are never sent.

Results stream out one element per handshake. The core sits behind the chip top-level pin mux, or an on-chip CPU bridge.

---
 rtl/sparse_mvm_core.sv | 186 ++++++++++++++++++
 tb/tb_sparse_mvm_core.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_mvm_core.sv
// Sparse matrix-vector multiply core: y = A*x with A streamed as COO triplets.
// Optional: define SPARSE_MVM_SAT_EN to clamp y to DW bits instead of truncating.
module sparse_mvm_core #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 20,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_row,
    input  logic [IW-1:0] in_col,
    input  logic [DW-1:0] in_data,
    input  logic          mat_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          busy,
    output logic [7:0]    nnz_count,
    output logic          idx_err
);

    typedef enum logic [2:0] {IDLE, LOAD_X, MAT, FLUSH, OUT} state_t;

    state_t state;

    logic signed [DW-1:0]   x   [N];
    logic signed [AW-1:0]   acc [N];
    logic [IW-1:0]          k;
    logic signed [2*DW-1:0] prod_r;
    logic [IW-1:0]          row_r;
    logic                   v_r;

    logic                   accept;
    logic                   load_acc;
    logic                   mat_acc;
    logic                   row_ok;
    logic                   col_ok;
    logic                   trip_ok;
    logic signed [DW-1:0]   x_sel;
    logic signed [2*DW-1:0] prod;

    assign accept   = in_valid && in_ready;
    assign load_acc = accept && (state == LOAD_X);
    assign mat_acc  = accept && (state == MAT);
    assign row_ok   = 32'(in_row) < N;
    assign col_ok   = 32'(in_col) < N;
    assign trip_ok  = row_ok && col_ok;
    assign x_sel    = col_ok ? x[in_col] : '0;
    assign prod     = $signed(in_data) * x_sel;

    // Job sequencing, handshake flags and per-job status counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            k         <= '0;
            nnz_count <= '0;
            idx_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD_X;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        k         <= '0;
                        nnz_count <= '0;
                        idx_err   <= 1'b0;
                    end
                end
                LOAD_X: begin
                    if (load_acc) begin
                        if (k == IW'(N - 1)) begin
                            state <= MAT;
                            k     <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                MAT: begin
                    if (mat_acc) begin
                        if (!trip_ok) begin
                            idx_err <= 1'b1;
                        end else if (nnz_count != 8'hFF) begin
                            nnz_count <= nnz_count + 8'd1;
                        end
                    end
                    if (mat_done) begin
                        state    <= FLUSH;
                        in_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                    out_idx   <= '0;
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_idx == IW'(N - 1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            busy      <= 1'b0;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture the x vector in arrival order during LOAD_X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) x[i] <= '0;
        end else if (load_acc) begin
            x[k] <= in_data;
        end
    end

    // Stage 1: multiply an accepted triplet; bad indices are dropped here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r <= '0;
            row_r  <= '0;
            v_r    <= 1'b0;
        end else begin
            v_r <= mat_acc && trip_ok;
            if (mat_acc) begin
                prod_r <= prod;
                row_r  <= in_row;
            end
        end
    end

    // Stage 2: single-cycle read-modify-write, so same-row bursts never stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else if (state == IDLE && start) begin
            for (int i = 0; i < N; i++) acc[i] <= '0;
        end else if (v_r) begin
            acc[row_r] <= acc[row_r]
                        + {{(AW - 2*DW){prod_r[2*DW-1]}}, prod_r};
        end
    end

`ifdef SPARSE_MVM_SAT_EN
    localparam logic signed [AW-1:0] SMAX = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    logic signed [AW-1:0] acc_sel;

    assign acc_sel = acc[out_idx];

    // Clamp the selected accumulator into the signed DW-bit range
    always_comb begin
        out_data = acc_sel[DW-1:0];
        if (acc_sel > SMAX) begin
            out_data = SMAX[DW-1:0];
        end else if (acc_sel < SMIN) begin
            out_data = SMIN[DW-1:0];
        end
    end
`else
    // Two's-complement truncation of the selected accumulator
    always_comb begin
        out_data = acc[out_idx][DW-1:0];
    end
`endif

endmodule

// File: tb/tb_sparse_mvm_core.sv
// Randomized bench for sparse_mvm_core against an arithmetic reference model.
// A second N=3 instance exercises out-of-range index handling.
module tb_sparse_mvm_core;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          mat_done = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] in_row = '0;
    logic [IW-1:0] in_col = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic          idx_err;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic [7:0]    nnz_count;

    logic          e_start = 1'b0;
    logic          e_in_valid = 1'b0;
    logic          e_mat_done = 1'b0;
    logic          e_out_ready = 1'b0;
    logic [1:0]    e_in_row = '0;
    logic [1:0]    e_in_col = '0;
    logic [DW-1:0] e_in_data = '0;
    logic          e_in_ready;
    logic          e_out_valid;
    logic          e_busy;
    logic          e_idx_err;
    logic [DW-1:0] e_out_data;
    logic [1:0]    e_out_idx;
    logic [7:0]    e_nnz_count;

    int errors = 0;
    int checks = 0;

    int tx[N];
    int tr[$];
    int tc[$];
    int tv[$];

    sparse_mvm_core #(.N(N), .DW(DW), .AW(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .in_col(in_col), .in_data(in_data),
        .mat_done(mat_done), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .busy(busy),
        .nnz_count(nnz_count), .idx_err(idx_err)
    );

    sparse_mvm_core #(.N(3), .DW(DW), .AW(AW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(e_start),
        .in_valid(e_in_valid), .in_ready(e_in_ready),
        .in_row(e_in_row), .in_col(e_in_col), .in_data(e_in_data),
        .mat_done(e_mat_done), .out_valid(e_out_valid),
        .out_ready(e_out_ready), .out_data(e_out_data),
        .out_idx(e_out_idx), .busy(e_busy),
        .nnz_count(e_nnz_count), .idx_err(e_idx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_y(input int r);
        longint s;
        logic signed [AW-1:0] w;
        s = 0;
        foreach (tr[i]) begin
            if (tr[i] == r && tr[i] < N && tc[i] < N) begin
                s += longint'(tv[i]) * longint'(tx[tc[i]]);
            end
        end
        w = AW'(s);
`ifdef SPARSE_MVM_SAT_EN
        if (w > (2 ** (DW - 1)) - 1) return (2 ** (DW - 1)) - 1;
        if (w < -(2 ** (DW - 1))) return -(2 ** (DW - 1));
        return longint'(w);
`else
        return longint'($signed(w[DW-1:0]));
`endif
    endfunction

    function automatic longint model_nnz();
        int n;
        n = 0;
        foreach (tr[i]) if (tr[i] < N && tc[i] < N) n++;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic clear_trips();
        tr.delete();
        tc.delete();
        tv.delete();
    endtask

    task automatic add_trip(input int r, input int c, input int v);
        tr.push_back(r);
        tc.push_back(c);
        tv.push_back(v);
    endtask

    task automatic step_in(input bit v, input int r, input int c,
                           input int d, input bit done, output bit ok);
        in_valid = v;
        in_row   = IW'(r);
        in_col   = IW'(c);
        in_data  = DW'(d);
        mat_done = done;
        ok       = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        mat_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "/in_ready"}, in_ready, 0);
        check({tag, "/out_valid"}, out_valid, 0);
        check({tag, "/out_data"}, out_data, 0);
        check({tag, "/out_idx"}, out_idx, 0);
        check({tag, "/busy"}, busy, 0);
        check({tag, "/nnz"}, nnz_count, 0);
        check({tag, "/idx_err"}, idx_err, 0);
    endtask

    task automatic load_x(input bit gaps);
        bit ok;
        int budget;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start", busy, 1);
        for (int k = 0; k < N; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) step_in(0, 0, 0, 0, 0, ok);
            budget = 0;
            do begin
                step_in(1, 0, 0, tx[k], 0, ok);
                budget++;
            end while (!ok && budget < 20);
            check("load_accept", ok, 1);
        end
    endtask

    task automatic run_job(input string tag, input bit gaps,
                           input bit done_last, input int hold_at);
        bit ok;
        bit rdy;
        bit done;
        int i;
        int budget;
        int hold;
        load_x(gaps);
        for (int t = 0; t < tr.size(); t++) begin
            if (gaps && $urandom_range(0, 2) == 0) step_in(0, 0, 0, 0, 0, ok);
            done = done_last && (t == tr.size() - 1);
            step_in(1, tr[t], tc[t], tv[t], done, ok);
            if (t < 4) check({tag, "/mat_ready"}, ok, 1);
        end
        if (!(done_last && tr.size() > 0)) begin
            step_in(0, 0, 0, 0, 1, ok);
            check({tag, "/done_ready"}, ok, 1);
        end
        check({tag, "/flush_ready"}, in_ready, 0);
        check({tag, "/flush_valid"}, out_valid, 0);
        check({tag, "/nnz"}, nnz_count, model_nnz());
        check({tag, "/idx_err"}, idx_err, 0);
        @(negedge clk);
        i = 0;
        budget = 0;
        hold = 5;
        while (i < N && budget < 200) begin
            check({tag, "/out_valid"}, out_valid, 1);
            check({tag, "/out_idx"}, out_idx, i);
            check({tag, "/y"}, $signed(out_data), model_y(i));
            if (i == hold_at && hold > 0) begin
                rdy = 1'b0;
                hold--;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            out_ready = rdy;
            @(negedge clk);
            out_ready = 1'b0;
            if (rdy) i++;
            budget++;
        end
        check({tag, "/drained"}, i, N);
        check({tag, "/end_valid"}, out_valid, 0);
        check({tag, "/end_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        mat_done = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_small_err();
        e_start = 1'b1;
        @(negedge clk);
        e_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("e_load_ready", e_in_ready, 1);
            e_in_valid = 1'b1;
            e_in_data = DW'(k + 1);
            @(negedge clk);
        end
        e_in_row = 2'd0;
        e_in_col = 2'd0;
        e_in_data = 8'd5;
        @(negedge clk);
        e_in_row = 2'd3;
        e_in_col = 2'd0;
        e_in_data = 8'd9;
        @(negedge clk);
        check("e_idx_err", e_idx_err, 1);
        e_in_valid = 1'b0;
        e_mat_done = 1'b1;
        @(negedge clk);
        e_mat_done = 1'b0;
        check("e_nnz", e_nnz_count, 1);
        @(negedge clk);
        e_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("e_out_valid", e_out_valid, 1);
            check("e_out_idx", e_out_idx, i);
            check("e_y", $signed(e_out_data), (i == 0) ? 5 : 0);
            @(negedge clk);
        end
        e_out_ready = 1'b0;
        check("e_end_busy", e_busy, 0);
        check("e_err_sticky", e_idx_err, 1);
    endtask

    initial begin
        bit ok;
        @(negedge clk);
        do_reset();
        run_small_err();

        tx = '{1, 2, 3, 4};
        clear_trips();
        for (int r = 0; r < 4; r++) add_trip(r, r, 1);
        run_job("identity", 0, 0, 1);

        tx = '{5, -3, 0, 0};
        clear_trips();
        add_trip(2, 0, 2);
        add_trip(2, 1, 4);
        add_trip(2, 0, -1);
        run_job("same_row", 0, 0, -1);

        clear_trips();
        run_job("empty", 0, 0, -1);

        tx = '{0, 0, 0, 2};
        clear_trips();
        add_trip(1, 3, 7);
        run_job("simul_done", 0, 1, -1);

        tx = '{127, 0, 0, 0};
        clear_trips();
        add_trip(0, 0, 127);
        add_trip(0, 0, 127);
        run_job("saturate", 0, 0, -1);

        tx = '{9, 9, 9, 9};
        load_x(0);
        step_in(1, 0, 0, 3, 0, ok);
        step_in(1, 1, 1, 3, 0, ok);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        tx = '{1, 2, 3, 4};
        clear_trips();
        for (int r = 0; r < 4; r++) add_trip(r, r, 1);
        run_job("after_reset", 0, 0, -1);

        for (int j = 0; j < 6; j++) begin
            foreach (tx[i]) tx[i] = int'($urandom_range(0, 255)) - 128;
            clear_trips();
            for (int t = 0; t < int'($urandom_range(0, 12)); t++) begin
                add_trip(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                         int'($urandom_range(0, 255)) - 128);
            end
            run_job("random", 1, bit'($urandom_range(0, 1)), -1);
        end

        foreach (tx[i]) tx[i] = int'($urandom_range(0, 255)) - 128;
        clear_trips();
        for (int t = 0; t < 300; t++) begin
            add_trip(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
                     int'($urandom_range(0, 255)) - 128);
        end
        run_job("nnz_sat", 0, 1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
